// File: rtl/ram_sp_init.sv
// ram_sp_init: single-port synchronous RAM, registered read port with a
// one-cycle read-valid strobe, and an optional hardware fill sequencer.
// Define RAM_INIT_EN to build the fill sequencer (IDLE/FILL FSM). When it is
// undefined, init_start is ignored and busy/init_done are tied low.
module ram_sp_init #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int INIT_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              select,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              init_start,
    output logic              busy,
    output logic              init_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              host_acc;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_val;

    // host requests are dropped, not queued, while the fill owns the array
    assign host_acc = select & ~busy;

`ifdef RAM_INIT_EN
    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [DATA_W-1:0] STEP = DATA_W'(INIT_STEP);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    // fill_acc tracks (cnt * INIT_STEP) mod 2**DATA_W incrementally, so the
    // per-address product is a running sum instead of a full multiplier
    logic [DATA_W-1:0] fill_acc;

    // fill sequencer: walks every address once, then pulses init_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_acc  <= '0;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state <= FILL;
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    cnt      <= cnt + 1'b1;
                    fill_acc <= fill_acc + STEP;
                    if (&cnt) begin
                        // last address written; cnt wraps to 0 on its own
                        state     <= IDLE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        fill_acc  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fill_we   = (state == FILL);
    assign fill_addr = cnt;
    assign fill_val  = fill_acc;
`else
    logic unused_init_start;

    assign unused_init_start = init_start;
    assign busy              = 1'b0;
    assign init_done         = 1'b0;
    assign fill_we           = 1'b0;
    assign fill_addr         = '0;
    assign fill_val          = '0;
`endif

    // array write port: fill has priority (host is locked out while busy anyway)
    always_ff @(posedge clk) begin
        if (fill_we)
            mem[fill_addr] <= fill_val;
        else if (host_acc && write)
            mem[address] <= data_in;
    end

    // registered read; data_out holds its value on writes and idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= host_acc & ~write;
            if (host_acc && !write)
                data_out <= mem[address];
        end
    end

endmodule

// File: tb/tb_ram_sp_init.sv
// tb_ram_sp_init: scoreboard bench for ram_sp_init at default parameters.
// Reads push their expected data and due cycle; a negedge monitor pops and
// compares whenever rd_valid is seen. Hardware-fill tests build only when
// RAM_INIT_EN is defined.
module tb_ram_sp_init;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          select = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          init_start = 1'b0;
    logic          busy;
    logic          init_done;

    ram_sp_init #(.DATA_W(DW), .ADDR_W(AW), .INIT_STEP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .select    (select),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .init_start(init_start),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        select = 1'b1; write = 1'b1; address = a; data_in = d;
        tick();
        select = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        exp_t e;
        e.d = exp;
        e.due = cyc + 1;
        q.push_back(e);
        select = 1'b1; write = 1'b0; address = a;
        tick();
        select = 1'b0;
    endtask

    // monitor: every rd_valid must match the oldest outstanding read, on time
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("rv_spurious", {31'd0, rd_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rd_data", {24'd0, data_out}, {24'd0, e.d});
                chk("rd_lat", cyc, e.due);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("rv_missing", {31'd0, rd_valid}, 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idn;
        logic [AW-1:0] a;

        // reset values
        tick();
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // host fill then back-to-back reads
        for (int k = 0; k < DEPTH; k++) wr(AW'(k), DW'((2 * k) & 8'hFF));
        rd(10'd0, 8'd0);
        rd(10'd5, 8'd10);
        rd(10'd511, 8'd254);
        rd(10'd1023, 8'd254);
        tick();

        // write/read ordering; later write leaves data_out alone
        wr(10'd9, 8'h3C);
        rd(10'd9, 8'h3C);
        wr(10'd9, 8'h11);
        tick();
        chk("dout_hold_wr", {24'd0, data_out}, 32'h3C);
        chk("rv_after_wr", {31'd0, rd_valid}, 32'd0);
        rd(10'd9, 8'h11);
        tick();

`ifdef RAM_INIT_EN
        // scramble contents so the hardware fill is observable
        for (int k = 0; k < DEPTH; k++) wr(AW'(k), 8'h5A);

        // hardware fill with host accesses attempted while busy
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        chk("fill_busy_rise", {31'd0, busy}, 32'd1);
        n = 0;
        idn = 0;
        while (busy === 1'b1 && n < 2000) begin
            if (init_done === 1'b1) idn++;
            select = (n == 3) || (n == 10) || (n == 1010);
            write = (n != 10);
            address = (n == 3) ? 10'd7 : (n == 10) ? 10'd20 : 10'd1000;
            data_in = 8'hAA;
            tick();
            select = 1'b0; write = 1'b0;
            n++;
        end
        chk("fill_busy_cycles", n, DEPTH);
        chk("fill_done_early", idn, 0);
        chk("fill_done_pulse", {31'd0, init_done}, 32'd1);
        tick();
        chk("fill_done_once", {31'd0, init_done}, 32'd0);

        rd(10'd7, 8'd14);
        rd(10'd1000, 8'd208);
        void'($urandom(35));
        for (int i = 0; i < 20; i++) begin
            a = AW'($urandom_range(DEPTH - 1, 0));
            rd(a, DW'((2 * int'(a)) & 8'hFF));
        end
        tick();

        // reset mid-fill; fill started alongside a host write to 200
        wr(10'd50, 8'h77);
        rd(10'd5, 8'd10);
        init_start = 1'b1; select = 1'b1; write = 1'b1; address = 10'd200; data_in = 8'h77;
        tick();
        init_start = 1'b0; select = 1'b0; write = 1'b0;
        chk("fill2_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data_out", {24'd0, data_out}, 32'd0);
        chk("abort_init_done", {31'd0, init_done}, 32'd0);
        #1;
        rst = 1'b0;
        idn = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (init_done === 1'b1 || busy === 1'b1) idn++;
        end
        chk("abort_quiet", idn, 0);
        rd(10'd50, 8'd100);
        rd(10'd200, 8'h77);
        tick();
`else
        // sequencer absent: init_start must have no effect
        init_start = 1'b1;
        idn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || init_done !== 1'b0) idn++;
        end
        init_start = 1'b0;
        chk("noinit_flags", idn, 0);
        wr(10'd300, 8'hC3);
        rd(10'd300, 8'hC3);
        rd(10'd5, 8'd10);
        tick();
`endif

        tick();
        tick();
        chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
